// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU datapath control sequencer.
package alu_seq_pkg;

  localparam int OP_W_DEF = 3;
  localparam int RA_W_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  // Opcode encoding understood by the ALU's opControl input.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences register-file reads, ALU operand loads, result latch and write-back
// over a shared bus so that exactly one driver owns the bus in any cycle.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [OP_W-1:0]  instr_op,
  input  logic [RA_W-1:0]  instr_src_a,
  input  logic [RA_W-1:0]  instr_src_b,
  input  logic [RA_W-1:0]  instr_dst,
  output logic             instr_ready,
  input  logic             abort,
  output logic             reg_rd_en,
  output logic [RA_W-1:0]  reg_rd_addr,
  output logic             reg_wr_en,
  output logic [RA_W-1:0]  reg_wr_addr,
  output logic [OP_W-1:0]  opControl,
  output logic             ALUin0,
  output logic             ALUin1,
  output logic             ALUOutLatch,
  output logic             ALUOutEn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  state_t          state;
  state_t          state_next;
  logic            ready_en;
  logic            accept;
  logic [OP_W-1:0] cur_op;
  logic [RA_W-1:0] cur_src_a;
  logic [RA_W-1:0] cur_src_b;
  logic [RA_W-1:0] cur_dst;

  // ready_en keeps the handshake closed until the first edge after reset release.
  assign instr_ready = ready_en && ((state == IDLE) || (state == WRITE)) && !abort;
  assign accept      = instr_valid && instr_ready;
  assign opControl   = cur_op;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = accept ? LOAD_A : IDLE;
      LOAD_A:  state_next = abort ? IDLE : LOAD_B;
      LOAD_B:  state_next = abort ? IDLE : EXEC;
      EXEC:    state_next = abort ? IDLE : WRITE;
      WRITE:   state_next = accept ? LOAD_A : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state, so each one is a clean flop
  // output that still lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ready_en    <= 1'b0;
      cur_op      <= '0;
      cur_src_a   <= '0;
      cur_src_b   <= '0;
      cur_dst     <= '0;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      ALUin0      <= 1'b0;
      ALUin1      <= 1'b0;
      ALUOutLatch <= 1'b0;
      ALUOutEn    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      op_count    <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (accept) begin
        cur_op    <= instr_op;
        cur_src_a <= instr_src_a;
        cur_src_b <= instr_src_b;
        cur_dst   <= instr_dst;
      end
      reg_rd_en   <= (state_next == LOAD_A) || (state_next == LOAD_B);
      // LOAD_A is only ever entered on an accept, so its address comes straight
      // from the instruction being captured on this edge.
      if (state_next == LOAD_A) begin
        reg_rd_addr <= instr_src_a;
      end else if (state_next == LOAD_B) begin
        reg_rd_addr <= cur_src_b;
      end else begin
        reg_rd_addr <= '0;
      end
      ALUin0      <= (state_next == LOAD_A);
      ALUin1      <= (state_next == LOAD_B);
      ALUOutLatch <= (state_next == EXEC);
      ALUOutEn    <= (state_next == WRITE);
      reg_wr_en   <= (state_next == WRITE);
      reg_wr_addr <= (state_next == WRITE) ? cur_dst : '0;
      done        <= (state_next == WRITE);
      busy        <= (state_next != IDLE);
      if (state == WRITE) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer: a transaction-level model predicts each
// instruction's strobe phases and write-back value, and a bus model plays the datapath.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int OP_W  = 3;
  localparam int RA_W  = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic [OP_W-1:0]  instr_op;
  logic [RA_W-1:0]  instr_src_a;
  logic [RA_W-1:0]  instr_src_b;
  logic [RA_W-1:0]  instr_dst;
  logic             instr_ready;
  logic             abort;
  logic             reg_rd_en;
  logic [RA_W-1:0]  reg_rd_addr;
  logic             reg_wr_en;
  logic [RA_W-1:0]  reg_wr_addr;
  logic [OP_W-1:0]  opControl;
  logic             ALUin0;
  logic             ALUin1;
  logic             ALUOutLatch;
  logic             ALUOutEn;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_sequencer #(.OP_W(OP_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_op(instr_op),
    .instr_src_a(instr_src_a), .instr_src_b(instr_src_b), .instr_dst(instr_dst),
    .instr_ready(instr_ready), .abort(abort),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .opControl(opControl), .ALUin0(ALUin0), .ALUin1(ALUin1),
    .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn),
    .busy(busy), .done(done), .op_count(op_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         acc;
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] d;
  } tx_t;

  tx_t         q[$];
  int          cyc = 0;
  int          exp_count = 0;
  int          done_cycles[$];
  logic [15:0] env_rf[4];
  logic [15:0] ref_rf[4];
  logic [15:0] a_lat, b_lat, out_lat;
  bit          last_acc;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NOT:  return ~x;
      OP_SHL:  return x << 1;
      default: return x >> 1;
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the in-flight
  // instruction's phase (cycles since accept), play the datapath, advance the model.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] d, input bit ab);
    int  ph;
    bit  e_ready;
    tx_t t;
    instr_valid = v; instr_op = op; instr_src_a = a; instr_src_b = b; instr_dst = d; abort = ab;
    #1;
    ph      = (q.size() > 0) ? (cyc - q[0].acc) : 0;
    e_ready = !ab && ((q.size() == 0) || (ph == 4));
    check("ready",    instr_ready, e_ready);
    check("busy",     busy, q.size() > 0);
    check("op_count", op_count, exp_count);
    check("rd_en",    reg_rd_en, (ph == 1) || (ph == 2));
    check("alu_in0",  ALUin0, ph == 1);
    check("alu_in1",  ALUin1, ph == 2);
    check("out_latch", ALUOutLatch, ph == 3);
    check("out_en",   ALUOutEn, ph == 4);
    check("wr_en",    reg_wr_en, ph == 4);
    check("done",     done, ph == 4);
    check("bus_excl", reg_rd_en & ALUOutEn, 0);
    if (ph > 0)  check("opcontrol", opControl, q[0].op);
    if (ph == 1) check("rd_addr_a", reg_rd_addr, q[0].a);
    if (ph == 2) check("rd_addr_b", reg_rd_addr, q[0].b);
    if (ph == 4) check("wr_addr",   reg_wr_addr, q[0].d);
    if (reg_rd_en && ALUin0) a_lat = env_rf[reg_rd_addr];
    if (reg_rd_en && ALUin1) b_lat = env_rf[reg_rd_addr];
    if (ALUOutLatch) out_lat = alu(opControl, a_lat, b_lat);
    if (reg_wr_en && ALUOutEn) env_rf[reg_wr_addr] = out_lat;
    if (ph == 4) begin
      t = q.pop_front();
      ref_rf[t.d] = alu(t.op, ref_rf[t.a], ref_rf[t.b]);
      check("wb_value", env_rf[t.d], ref_rf[t.d]);
      exp_count = (exp_count + 1) % (1 << CNT_W);
      done_cycles.push_back(cyc);
    end else if (ab && (ph >= 1) && (ph <= 3)) begin
      void'(q.pop_front());
    end
    last_acc = v && e_ready;
    if (last_acc) begin
      t.acc = cyc; t.op = op; t.a = a; t.b = b; t.d = d;
      q.push_back(t);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, op, a, b, d, 1'b0);
      if (last_acc) return;
    end
    check("issue_timeout", last_acc, 1);
  endtask

  task automatic issue_rand();
    issue(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)));
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) return;
      cycle(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  initial begin
    int acc_c;
    int cnt_saved;
    logic [15:0] r3_saved;
    rst = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_src_a = '0;
    instr_src_b = '0; instr_dst = '0; abort = 1'b0;
    for (int i = 0; i < 4; i++) env_rf[i] = 16'($urandom);
    env_rf[1] = 16'h0005;
    env_rf[2] = 16'h0003;
    for (int i = 0; i < 4; i++) ref_rf[i] = env_rf[i];
    a_lat = '0; b_lat = '0; out_lat = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", op_count, 0);
    check("rst_opcontrol", opControl, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", instr_ready, 1);

    // Single ADD: R1 + R2 -> R3
    done_cycles.delete();
    issue(OP_ADD, 2'd1, 2'd2, 2'd3);
    acc_c = cyc - 1;
    drain();
    check("single_r3", env_rf[3], 16'h0008);
    check("single_count", op_count, 1);
    check("single_done_seen", done_cycles.size(), 1);
    if (done_cycles.size() > 0) check("single_latency", done_cycles[0], acc_c + 4);

    // Reset asserted while the instruction sits in EXEC
    issue(OP_SUB, 2'd2, 2'd1, 2'd0);
    cycle(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    cycle(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    check("exec_before_reset", ALUOutLatch, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_latch", ALUOutLatch, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", instr_ready, 0);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_rd_en", reg_rd_en, 0);
    check("mid_rst_wr_en", reg_wr_en, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    q.delete();
    exp_count = 0;
    @(posedge clk); #1;
    cyc++;
    check("ready_after_mid_rst", instr_ready, 1);

    // Three back-to-back instructions
    done_cycles.delete();
    issue_rand(); issue_rand(); issue_rand();
    drain();
    check("b2b_count", op_count, 3);
    check("b2b_done_seen", done_cycles.size(), 3);
    if (done_cycles.size() == 3) begin
      check("b2b_spacing1", done_cycles[1] - done_cycles[0], 4);
      check("b2b_spacing2", done_cycles[2] - done_cycles[1], 4);
    end

    // Abort in LOAD_B: no write-back
    done_cycles.delete();
    r3_saved  = env_rf[3];
    cnt_saved = exp_count;
    issue(OP_XOR, 2'd1, 2'd2, 2'd3);
    cycle(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    cycle(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    repeat (5) cycle(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    check("abort_lb_r3", env_rf[3], r3_saved);
    check("abort_lb_count", op_count, cnt_saved);
    check("abort_lb_no_done", done_cycles.size(), 0);

    // Abort in WRITE with a new instruction waiting
    cnt_saved = exp_count;
    issue(OP_OR, 2'd0, 2'd1, 2'd2);
    repeat (3) cycle(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    cycle(1'b1, OP_AND, 2'd2, 2'd3, 2'd1, 1'b1);
    check("abort_wr_count", op_count, (cnt_saved + 1) % (1 << CNT_W));
    check("abort_wr_idle", busy, 0);
    issue(OP_AND, 2'd2, 2'd3, 2'd1);
    check("abort_wr_accept_idle", busy, 1);
    drain();

    // Randomised traffic with occasional aborts
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(9, 0) < 7), 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
            2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), ($urandom_range(19, 0) == 0));
    end
    drain();

    // Counter wrap
    for (int i = 0; (i < 300) && (exp_count != ((1 << CNT_W) - 1)); i++) begin
      issue_rand();
      drain();
    end
    check("pre_wrap_count", op_count, (1 << CNT_W) - 1);
    issue_rand();
    drain();
    check("wrap_count", op_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control sequencer for the 16-bit ALU datapath: two operand input registers, the ALU, an output register and the output tri-state buffer, all sharing one 16-bit bus with a small register file. The sequencer accepts one instruction at a time through a valid/ready handshake (opcode, two source registers, one destination register). It then drives the register-file read strobes and the datapath strobes `ALUin0`, `ALUin1`, `ALUOutLatch` and `ALUOutEn` in a fixed order so that only one driver is on the bus in any cycle. It sits between the instruction source and the datapath and is the only block that drives the datapath control pins.

## Interface
Parameters:
- `OP_W`, 3: opcode width; matches datapath `opControl`.
- `RA_W`, 2: register-file address width.
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present.
- `instr_op`  in  OP_W  ALU opcode.
- `instr_src_a`, `instr_src_b`, `instr_dst`  in  RA_W each  source A, source B and destination registers.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `abort`  in  1  synchronous cancel of the in-flight instruction.
- `reg_rd_en`  out  1  register file drives bus.
- `reg_rd_addr`  out  RA_W  register being read.
- `reg_wr_en`  out  1  register file captures bus.
- `reg_wr_addr`  out  RA_W  register being written.
- `opControl`  out  OP_W  ALU operation select.
- `ALUin0`, `ALUin1`  out  1  load enables for operand registers A and B.
- `ALUOutLatch`  out  1  output register load enable.
- `ALUOutEn`  out  1  output tri-state enable.
- `busy`  out  1  an instruction is in flight.
- `done`  out  1  one-cycle pulse on write-back.
- `op_count`  out  CNT_W  completed instructions; wraps.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE.
- Acceptance: an instruction is accepted on a rising edge where `instr_valid && instr_ready`. `instr_ready` = (state is IDLE or WRITE) and not `abort`. On accept, the op and the three addresses are captured into internal registers.
- Transitions:
  - IDLE to LOAD_A on accept.
  - LOAD_A to LOAD_B.
  - LOAD_B to EXEC.
  - EXEC to WRITE.
  - WRITE to LOAD_A if a new instruction is accepted in that cycle, otherwise WRITE to IDLE.
- Outputs by state (all registered-state decoded; every unlisted strobe is 0):
  - LOAD_A: `reg_rd_en`=1, `reg_rd_addr`=src_a, `ALUin0`=1.
  - LOAD_B: `reg_rd_en`=1, `reg_rd_addr`=src_b, `ALUin1`=1.
  - EXEC: `ALUOutLatch`=1.
  - WRITE: `ALUOutEn`=1, `reg_wr_en`=1, `reg_wr_addr`=dst, `done`=1.
- `opControl` holds the captured op from LOAD_A through WRITE. It keeps its last value in IDLE.
- `busy` = state is not IDLE.
- `op_count` increments by 1 in every WRITE cycle and wraps from 2^CNT_W-1 to 0.
- Bus exclusivity invariant: `reg_rd_en` and `ALUOutEn` are never both 1.
- `abort` in LOAD_A, LOAD_B or EXEC: next state is IDLE. No WRITE occurs and `op_count` is unchanged.
- `abort` in WRITE: the write-back completes, next state is IDLE, and no new instruction is accepted that cycle.
- `abort` in IDLE has no effect.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `op_count`=0, captured op/addresses=0. All strobes, `done` and `busy` are 0. `instr_ready`=0 while reset is asserted and 1 from the first cycle after release.
- Latency: accept at edge N; LOAD_A in cycle N+1; `done`/write-back in cycle N+4.
- Throughput: back-to-back instructions (accepted in WRITE) complete every 4 cycles. An instruction accepted from IDLE completes 4 cycles after the accept.
- Reset asserted mid-operation: the sequencer returns to IDLE immediately and asynchronously. All strobes drop without waiting for a clock.
- `instr_*` fields are sampled only at the accept edge. Later changes do not affect the in-flight instruction.

## Structure
- Package `alu_seq_pkg`:
  - state enum (IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, WRITE=4, 3-bit encoding);
  - opcode constants matching the ALU encoding;
  - `OP_W`/`RA_W` defaults.
- Single module. No sub-module; the counter and FSM are small enough to stay inline.

## Test plan
- Reset: hold `rst`=0 mid-EXEC.
  - Expect all strobes 0 immediately, `op_count`=0, `instr_ready`=0.
  - Release reset; expect `instr_ready`=1 on the next cycle.
- Single op: op=3'b000, src_a=1, src_b=2, dst=3, with the register-file model holding R1=16'h0005 and R2=16'h0003.
  - Expect LOAD_A to read addr 1, LOAD_B to read addr 2, then EXEC.
  - Expect WRITE to write R3=16'h0008, with `done` at accept+4 and `op_count`=1.
- Back-to-back: `instr_valid` held high for 3 instructions.
  - Expect `done` at cycles +4, +8, +12, `op_count`=3.
  - Expect `reg_rd_en`&`ALUOutEn` never both 1.
- Abort in LOAD_B: expect next state IDLE, no `reg_wr_en`, no `done`, `op_count` unchanged, R3 unchanged.
- Abort in WRITE with `instr_valid`=1: expect the write to complete (`op_count`+1), the new instruction not accepted, then acceptance from IDLE.
- Wrap: preload `op_count` to 16'hFFFF by running 65535 ops (or force the value) and run one more op; expect `op_count`=16'h0000.
